// File: rtl/mmu_req_sync_fifo.sv
// Clocked landing stage for the merged two-phase MMU request stream: synchronises
// i_drive, captures the payload into a small FIFO and returns o_free once it is stored.
module mmu_req_sync_fifo #(
    parameter int DATA_WIDTH  = 88,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_drive,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic                         o_free,
    output logic                         o_valid,
    output logic [DATA_WIDTH-1:0]        o_data,
    input  logic                         i_ready,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_level,
    output logic [CNT_WIDTH-1:0]         o_req_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_phase;
    logic                   r_free;
    logic                   r_valid;
    logic                   r_full;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_count;
    logic [CNT_WIDTH-1:0]   r_req_cnt;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_pending;
    logic                   w_push;
    logic                   w_pop;
    logic [LW-1:0]          w_count_nxt;

    // A new request is outstanding while the synchronised toggle differs from our phase.
    assign w_pending = r_sync[SYNC_STAGES-1] ^ r_phase;
    // Full is the registered (pre-edge) flag, so a pop never frees a slot for the same edge.
    assign w_push    = w_pending & ~r_full;
    assign w_pop     = r_valid & i_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync    <= '0;
            r_phase   <= 1'b0;
            r_free    <= 1'b0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_req_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_drive};
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_phase         <= ~r_phase;
                r_free          <= ~r_free;
                r_req_cnt       <= r_req_cnt + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_full  <= (w_count_nxt == LW'(DEPTH));
        end
    end

    assign o_free    = r_free;
    assign o_valid   = r_valid;
    assign o_full    = r_full;
    assign o_level   = r_count;
    assign o_req_cnt = r_req_cnt;
    assign o_data    = r_mem[r_rd_ptr];

endmodule
